// File: rtl/spi_frontend_pkg.sv
// Shared types and constants for the SPI byte front end.
package spi_frontend_pkg;

    localparam int BYTE_W    = 8;
    localparam int BIT_CNT_W = 3;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_e;

    // Idle levels of the pads so reset never fabricates an edge.
    localparam logic SCK_RST  = 1'b0;
    localparam logic CS_RST   = 1'b1;
    localparam logic PICO_RST = 1'b0;

endpackage

// File: rtl/spi_byte_frontend_sync_edge.sv
// Multi-flop synchroniser for one async pad plus a history flop
// for rise/fall detection in the system clock domain.
module sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;
    logic              hist_q;

    assign sync_d = {sync_q[STAGES-2:0], async_i};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= {STAGES{RST_VAL}};
            hist_q <= RST_VAL;
        end else begin
            sync_q <= sync_d;
            hist_q <= sync_q[STAGES-1];
        end
    end

    assign level_o = sync_q[STAGES-1];
    assign rise_o  = sync_q[STAGES-1] & ~hist_q;
    assign fall_o  = ~sync_q[STAGES-1] & hist_q;

endmodule

// File: rtl/spi_byte_frontend.sv
// SPI mode-0 slave front end: synchronises pads, assembles MSB-first
// bytes from PICO and serialises reply bytes onto POCI.
module spi_byte_frontend
    import spi_frontend_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic              sys_clock_i,
    input  logic              rst_i,
    input  logic              spi_clock_i,
    input  logic              spi_cs_i,
    input  logic              spi_pico_i,
    output logic              spi_poci_o,
    output logic              spi_poci_oe_o,
    input  logic [BYTE_W-1:0] tx_data_i,
    output logic              tx_req_o,
    output logic [BYTE_W-1:0] rx_data_o,
    output logic              rx_valid_o,
    output logic              frame_start_o,
    output logic              frame_end_o,
    output logic              busy_o
);

    logic sck_lvl, sck_rise, sck_fall;
    logic cs_lvl, cs_rise, cs_fall;
    logic pico_lvl, pico_rise, pico_fall;

    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(SCK_RST)) u_sck (
        .clk_i   (sys_clock_i),
        .rst_i   (rst_i),
        .async_i (spi_clock_i),
        .level_o (sck_lvl),
        .rise_o  (sck_rise),
        .fall_o  (sck_fall)
    );

    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(CS_RST)) u_cs (
        .clk_i   (sys_clock_i),
        .rst_i   (rst_i),
        .async_i (spi_cs_i),
        .level_o (cs_lvl),
        .rise_o  (cs_rise),
        .fall_o  (cs_fall)
    );

    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(PICO_RST)) u_pico (
        .clk_i   (sys_clock_i),
        .rst_i   (rst_i),
        .async_i (spi_pico_i),
        .level_o (pico_lvl),
        .rise_o  (pico_rise),
        .fall_o  (pico_fall)
    );

    logic unused_sync;
    assign unused_sync = ^{sck_lvl, cs_lvl, pico_rise, pico_fall};

    state_e                 state_q;
    logic [BIT_CNT_W-1:0]   bit_cnt_q;
    logic                   byte_done_q;
    logic [BYTE_W-2:0]      rx_shift_q;
    logic [BYTE_W-1:0]      tx_shift_q;
    logic [BYTE_W-1:0]      rx_data_q;
    logic                   poci_q;
    logic                   oe_q;
    logic                   rx_valid_q;
    logic                   tx_req_q;
    logic                   fstart_q;
    logic                   fend_q;

    always_ff @(posedge sys_clock_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            byte_done_q <= 1'b0;
            rx_shift_q  <= '0;
            tx_shift_q  <= '0;
            rx_data_q   <= '0;
            poci_q      <= 1'b0;
            oe_q        <= 1'b0;
            rx_valid_q  <= 1'b0;
            tx_req_q    <= 1'b0;
            fstart_q    <= 1'b0;
            fend_q      <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            tx_req_q   <= 1'b0;
            fstart_q   <= 1'b0;
            fend_q     <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (cs_fall) begin
                        state_q     <= ACTIVE;
                        bit_cnt_q   <= '0;
                        byte_done_q <= 1'b0;
                        tx_shift_q  <= tx_data_i;
                        poci_q      <= tx_data_i[BYTE_W-1];
                        oe_q        <= 1'b1;
                        fstart_q    <= 1'b1;
                        tx_req_q    <= 1'b1;
                    end
                end
                ACTIVE: begin
                    // CS release wins over any SCK edge in the same cycle.
                    if (cs_rise) begin
                        state_q     <= IDLE;
                        bit_cnt_q   <= '0;
                        byte_done_q <= 1'b0;
                        rx_shift_q  <= '0;
                        poci_q      <= 1'b0;
                        oe_q        <= 1'b0;
                        fend_q      <= 1'b1;
                    end else if (sck_rise) begin
                        rx_shift_q <= {rx_shift_q[BYTE_W-3:0], pico_lvl};
                        bit_cnt_q  <= bit_cnt_q + BIT_CNT_W'(1);
                        if (bit_cnt_q == '1) begin
                            rx_data_q   <= {rx_shift_q, pico_lvl};
                            rx_valid_q  <= 1'b1;
                            byte_done_q <= 1'b1;
                        end
                    end else if (sck_fall) begin
                        if (byte_done_q) begin
                            tx_shift_q  <= tx_data_i;
                            poci_q      <= tx_data_i[BYTE_W-1];
                            tx_req_q    <= 1'b1;
                            byte_done_q <= 1'b0;
                        end else begin
                            tx_shift_q <= tx_shift_q << 1;
                            poci_q     <= tx_shift_q[BYTE_W-2];
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign spi_poci_o    = poci_q;
    assign spi_poci_oe_o = oe_q;
    assign tx_req_o      = tx_req_q;
    assign rx_data_o     = rx_data_q;
    assign rx_valid_o    = rx_valid_q;
    assign frame_start_o = fstart_q;
    assign frame_end_o   = fend_q;
    assign busy_o        = (state_q == ACTIVE);

endmodule
